ifetch_stage: RTL

Instruction fetch stage for the single-cycle/pipelined DLX datapath. Holds the program counter and issues word fetches to instruction memory over a request/grant/response-valid protocol with variable latency. Buffers returned words and hands `instruction`/`inst_pc` to the decode stage over a valid/ready handshake. Redirects the fetch stream on a taken branch or jump, discarding stale in-flight responses.

---
 rtl/ifetch_stage.sv | 139 +++++++++++++
 1 files changed

// File: rtl/ifetch_stage.sv
// DLX instruction fetch: PC, in-order variable-latency imem port, small output buffer, redirect kill.
// Optional macro IFETCH_PREFETCH_EN widens the fetch window from one word to two.
module ifetch_stage #(
    parameter logic [0:31] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [0:31] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [0:31] imem_rdata,
    input  logic        redirect,
    input  logic [0:31] redirect_pc,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [0:31] instruction,
    output logic [0:31] inst_pc,
    output logic [1:0]  dbg_outstanding,
    output logic [1:0]  dbg_kill_cnt,
    output logic [1:0]  dbg_buf_count
);

`ifdef IFETCH_PREFETCH_EN
    localparam int CAP = 2;
`else
    localparam int CAP = 1;
`endif
    localparam logic [2:0] CAP_W = 3'(CAP);

    logic        run_q, run_d;
    logic [0:31] fetch_pc_q, fetch_pc_d;
    logic [1:0]  outstanding_q, outstanding_d;
    logic [1:0]  kill_cnt_q, kill_cnt_d;
    logic [1:0]  buf_count_q, buf_count_d;
    logic [0:31] buf_word_q [CAP];
    logic [0:31] buf_word_d [CAP];
    logic [0:31] buf_pc_q   [CAP];
    logic [0:31] buf_pc_d   [CAP];
    logic [0:31] pcq_q      [CAP];
    logic [0:31] pcq_d      [CAP];

    logic        grant;
    logic        resp;
    logic        keep;
    logic        pop;
    logic [1:0]  pcq_wr_idx;
    logic [1:0]  buf_wr_idx;
    logic [2:0]  occupancy;

    // run_q holds the request off until the first edge after reset release.
    assign occupancy  = {1'b0, outstanding_q} + {1'b0, buf_count_q};
    assign imem_req   = run_q && (occupancy < CAP_W);
    assign imem_addr  = fetch_pc_q;
    assign grant      = imem_req && imem_gnt;
    assign resp       = imem_rvalid && (outstanding_q != 2'd0);
    assign keep       = resp && (kill_cnt_q == 2'd0);
    assign inst_valid = (buf_count_q != 2'd0);
    assign pop        = inst_valid && inst_ready;
    assign pcq_wr_idx = outstanding_q - {1'b0, resp};
    assign buf_wr_idx = buf_count_q - {1'b0, pop};

    assign instruction     = buf_word_q[0];
    assign inst_pc         = buf_pc_q[0];
    assign dbg_outstanding = outstanding_q;
    assign dbg_kill_cnt    = kill_cnt_q;
    assign dbg_buf_count   = buf_count_q;

    always_comb begin
        run_d         = 1'b1;
        fetch_pc_d    = grant ? fetch_pc_q + 32'd4 : fetch_pc_q;
        outstanding_d = outstanding_q + {1'b0, grant} - {1'b0, resp};
        kill_cnt_d    = kill_cnt_q;
        buf_count_d   = buf_count_q + {1'b0, keep} - {1'b0, pop};
        pcq_d         = pcq_q;
        buf_word_d    = buf_word_q;
        buf_pc_d      = buf_pc_q;

        // Both queues keep their oldest entry at index 0; shift on removal, then append.
        if (resp) begin
            for (int i = 0; i < CAP - 1; i++) begin
                pcq_d[i] = pcq_q[i + 1];
            end
        end
        if (pop) begin
            for (int i = 0; i < CAP - 1; i++) begin
                buf_word_d[i] = buf_word_q[i + 1];
                buf_pc_d[i]   = buf_pc_q[i + 1];
            end
        end
        for (int i = 0; i < CAP; i++) begin
            if (grant && (pcq_wr_idx == 2'(i))) begin
                pcq_d[i] = fetch_pc_q;
            end
            if (keep && (buf_wr_idx == 2'(i))) begin
                buf_word_d[i] = imem_rdata;
                buf_pc_d[i]   = pcq_q[0];
            end
        end

        if (resp && (kill_cnt_q != 2'd0)) begin
            kill_cnt_d = kill_cnt_q - 2'd1;
        end

        // Every response still owed after this edge belongs to the old stream.
        if (redirect) begin
            fetch_pc_d  = redirect_pc;
            buf_count_d = 2'd0;
            kill_cnt_d  = outstanding_d;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            run_q         <= 1'b0;
            fetch_pc_q    <= RESET_PC;
            outstanding_q <= 2'd0;
            kill_cnt_q    <= 2'd0;
            buf_count_q   <= 2'd0;
            for (int i = 0; i < CAP; i++) begin
                buf_word_q[i] <= '0;
                buf_pc_q[i]   <= '0;
                pcq_q[i]      <= '0;
            end
        end else begin
            run_q         <= run_d;
            fetch_pc_q    <= fetch_pc_d;
            outstanding_q <= outstanding_d;
            kill_cnt_q    <= kill_cnt_d;
            buf_count_q   <= buf_count_d;
            for (int i = 0; i < CAP; i++) begin
                buf_word_q[i] <= buf_word_d[i];
                buf_pc_q[i]   <= buf_pc_d[i];
                pcq_q[i]      <= pcq_d[i];
            end
        end
    end

endmodule
